soc_system_cmd_out: RTL
=======================

Name: soc_system_cmd_out

Overview:
- Avalon-MM slave that carries 32-bit command words from the HPS into the FPGA fabric.
- It is the write-direction counterpart of the data_in read port.
- Words the HPS writes are buffered in a show-ahead FIFO and drained to fabric logic over a valid/ready stream.
- Status, control and a delivered-word counter are readable over the same slave.

Parameters:
- DEPTH, 16, FIFO depth in words; power of two, 2..128.
- LEVEL_W, 8, width of the level field; must hold DEPTH (log2(DEPTH)+1 <= 8).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select; qualifies write_n.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_data  out  32  FIFO head word to fabric.
- out_valid  out  1  out_data valid.
- out_ready  in  1  fabric accepts the word.

Behaviour:
- Reset state (async, on reset_n=0): readdata=0, FIFO empty, out_valid=0, out_data=0, enable=0, overflow=0, last_wr=0, delivered=0.
- Register map, write side:
  - addr0 DATA: write pushes writedata into the FIFO and updates last_wr.
  - addr1 STATUS: write with bit2=1 clears overflow; other bits ignored.
  - addr2 CTRL: bit0 = enable (stored); bit1 = flush (one-shot, not stored).
  - addr3 COUNT: any write clears delivered to 0.
- Register map, read side:
  - addr0 returns last_wr.
  - addr1 returns {16'b0, level[LEVEL_W-1:0], 5'b0, overflow, full, empty}.
  - addr2 returns {31'b0, enable}.
  - addr3 returns delivered.
- Read timing: readdata is registered every clock from the current address, giving fixed 1-cycle read latency. Reads have no side effects.
- Stream output:
  - out_valid = enable & !empty.
  - out_data = head word, combinational from FIFO storage; 0 when empty.
  - Transfer (pop) occurs when out_valid & out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
- Push/pop rules, evaluated per cycle:
  - Push accepted if !full, or if a pop happens in the same cycle.
  - Push while full with no pop: word dropped, overflow sets (sticky), FIFO unchanged.
  - Simultaneous push and pop: level unchanged, pointers both advance.
  - Pointers wrap modulo DEPTH.
  - level is 0..DEPTH; empty = (level==0); full = (level==DEPTH).
- Flush:
  - Resets pointers and level to 0 in that cycle's update.
  - Any pop in the same cycle is cancelled: the delivered count does not increment and the fabric must treat the word as discarded.
  - Flush does not change enable, overflow or delivered.
  - The enable value in the same CTRL write takes effect normally.
- Enable:
  - enable=0 holds words in the FIFO; pushes are still accepted.
  - Clearing enable forces out_valid low from the next cycle.
- delivered:
  - Increments by 1 on each pop; wraps 0xFFFFFFFF -> 0.
  - A COUNT write in the same cycle as a pop results in 0 (clear wins).
- Overflow set and clear in the same cycle: set wins.
- Reset asserted mid-transfer: everything returns to reset state immediately; the FIFO contents are lost.
- The HPS write path is never back-pressured: no waitrequest, and every write completes in one cycle.

Test Plan:
- Reset, then read addr1 -> readdata=0x00000001 one cycle after the address is applied; out_valid=0.
- Write 0xA5A5_0001, 0xA5A5_0002 to addr0 with enable=0 -> addr1 reads level=2 (0x00000200); out_valid stays 0. Then write addr2=1 with out_ready=1 -> out_data 0xA5A5_0001 then 0xA5A5_0002 on consecutive cycles; addr3 reads 2; addr1 reads 0x00000001.
- enable=0, write 17 words (DEPTH=16) -> level=16; full=1; overflow=1 (addr1 = 0x00001006); the 17th word is not delivered after enabling. Write addr1=0x4 -> overflow clears.
- FIFO full, enable=1, out_ready=1, write addr0 in the same cycle -> push accepted; level stays 16; overflow stays 0.
- Toggle out_ready randomly over 100 words with pointer wrap -> delivered order equals written order; out_data stable while stalled; addr3 reads 100.
- 5 words queued, enable=1, out_ready=1, write addr2=0x3 -> that cycle's pop is cancelled (addr3 unchanged); level=0 next cycle; out_valid=0. Assert reset_n=0 mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/soc_system_cmd_out.sv
// Avalon-MM command port: HPS writes 32-bit words into a show-ahead FIFO that
// drains to fabric over valid/ready; status, control and a delivered counter are readable.
module soc_system_cmd_out #(
    parameter int DEPTH   = 16,
    parameter int LEVEL_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [LEVEL_W-1:0] level_reg, level_next;
    logic               enable_reg, overflow_reg;
    logic [31:0]        last_wr_reg, delivered_reg;

    logic        wr_en, data_wr, status_wr, ctrl_wr, count_wr;
    logic        flush, pop, pop_eff, push_ok, overflow_set;
    logic        full, empty;
    logic [31:0] status_word;

    assign wr_en     = chipselect & ~write_n;
    assign data_wr   = wr_en && (address == 2'd0);
    assign status_wr = wr_en && (address == 2'd1);
    assign ctrl_wr   = wr_en && (address == 2'd2);
    assign count_wr  = wr_en && (address == 2'd3);
    assign flush     = ctrl_wr & writedata[1];

    assign empty     = (level_reg == '0);
    assign full      = (level_reg == LEVEL_W'(DEPTH));
    assign out_valid = enable_reg & ~empty;
    assign out_data  = empty ? 32'd0 : mem[rd_ptr_reg];

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign pop          = out_valid & out_ready;
    assign pop_eff      = pop & ~flush;
    assign push_ok      = data_wr & (~full | pop);
    assign overflow_set = data_wr & full & ~pop;

    assign status_word = 32'({level_reg, 5'b0, overflow_reg, full, empty});

    always_comb begin
        level_next = level_reg;
        if (flush)
            level_next = '0;
        else if (push_ok && !pop_eff)
            level_next = level_reg + LEVEL_W'(1);
        else if (!push_ok && pop_eff)
            level_next = level_reg - LEVEL_W'(1);
    end

    // Storage carries no reset so it can map onto RAM; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= writedata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            enable_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            last_wr_reg   <= 32'd0;
            delivered_reg <= 32'd0;
        end else begin
            level_reg <= level_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push_ok)
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop_eff)
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (ctrl_wr)
                enable_reg <= writedata[0];
            if (overflow_set)
                overflow_reg <= 1'b1;
            else if (status_wr && writedata[2])
                overflow_reg <= 1'b0;
            if (data_wr)
                last_wr_reg <= writedata;
            if (count_wr)
                delivered_reg <= 32'd0;
            else if (pop_eff)
                delivered_reg <= delivered_reg + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            case (address)
                2'd0:    readdata <= last_wr_reg;
                2'd1:    readdata <= status_word;
                2'd2:    readdata <= {31'd0, enable_reg};
                default: readdata <= delivered_reg;
            endcase
        end
    end
endmodule
